hilo_div_ctrl: RTL and testbench
================================

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- op_valid  in  1  operation request
- op  in  3  001 DIV, 010 MTHI, 011 MTLO, 100 CLRERR; others reserved
- wdata  in  32  divisor for DIV; write data for MTHI/MTLO
- op_ready  out  1  high only in IDLE; request accepted when op_valid & op_ready at a rising edge
- done  out  1  one-cycle completion pulse
- done_err  out  1  qualifies done: the completed DIV faulted
- err_sticky  out  1  set by any faulted DIV; cleared only by CLRERR or reset
- hi  out  32  HI register
- lo  out  32  LO register
- div_dnd  out  64  registered dividend to downstream divider
- div_der  out  32  registered divisor to downstream divider
- div_quo  in  32  divider quotient, registered in divider one edge after sampling inputs
- div_rem  in  32  divider remainder, same timing
- div_err  in  1  divider fault (zero divisor or overflow), same timing

Function
REQ-003 States SHALL be IDLE, DRIVE and WAIT, encoded in 2 bits; encoding 11 SHALL return to IDLE on the next edge.
REQ-004 In IDLE, op_ready SHALL be 1; in DRIVE and WAIT it SHALL be 0, and op_valid SHALL be ignored with no state effect.
REQ-005 Accepted DIV (edge E0):
- div_dnd SHALL load {hi,lo} and div_der SHALL load wdata.
- State SHALL go IDLE->DRIVE.
REQ-006 At edge E1 (divider samples div_dnd/div_der), state SHALL go DRIVE->WAIT; div_dnd/div_der SHALL hold.
REQ-007 At edge E2, state SHALL go WAIT->IDLE and the block SHALL capture the divider outputs:
- div_err=0: lo<=div_quo, hi<=div_rem, done=1, done_err=0.
- div_err=1: hi/lo unchanged, done=1, done_err=1, err_sticky=1.
REQ-008 DIV latency SHALL be exactly 2 edges from acceptance to the done pulse; op_ready SHALL re-assert in the cycle done is high, so back-to-back DIVs give a throughput of one per 3 cycles.
REQ-009 MTHI/MTLO SHALL write wdata to hi/lo at the accept edge, pulse done with done_err=0, and stay in IDLE.
REQ-010 CLRERR SHALL clear err_sticky at the accept edge and pulse done with done_err=0.
REQ-011 A reserved op SHALL be accepted with no effect and no done pulse.
REQ-012 done and done_err SHALL be 0 in every cycle except the single cycle after a completing edge.
REQ-013 div_dnd/div_der SHALL change only on DIV acceptance or reset.
REQ-014 Divider outputs SHALL be ignored in IDLE and DRIVE; a stale div_err SHALL never set err_sticky.
REQ-015 hi/lo SHALL be visible continuously; a DIV reads hi/lo as they stand at its accept edge, including the value written by an MTHI/MTLO completed on the preceding edge.

Reset
REQ-016 While rst=1, outputs SHALL be: state IDLE, hi=0, lo=0, div_dnd=0, div_der=0, done=0, done_err=0, err_sticky=0, op_ready=1.
REQ-017 Reset asserted in DRIVE or WAIT SHALL abort the DIV immediately; a divider result arriving after reset release SHALL be discarded and SHALL not alter hi/lo.
REQ-018 After rst deasserts, the first rising edge SHALL be able to accept an operation.

Verification
REQ-019 The bench SHALL cover these scenarios:
- MTHI 0, MTLO 100, DIV wdata=7 -> done 2 edges after accept, lo=14, hi=2, done_err=0.
- MTHI 0xFFFFFFFF, MTLO 0xFFFFFF9C, DIV wdata=7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE.
- hi=0, lo=5, DIV wdata=0 -> done=1, done_err=1, err_sticky=1, hi/lo unchanged; then CLRERR -> err_sticky=0.
- DIV accepted, op_valid=1 MTLO 0x55 held during DRIVE/WAIT -> op_ready=0, no write, MTLO accepted on the edge after done.
- rst pulsed during WAIT -> all outputs at reset values, no done, hi/lo stay 0 despite divider output.
- Reserved op 111 -> no done, no register change.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl
//   Owns the HI/LO register pair and sequences 64/32 divisions through an
//   external, one-edge-latency divider. Also handles direct writes to HI/LO
//   and clearing of the sticky divide-fault flag.
//
//   Handshake: an operation is accepted on a rising edge where
//   op_valid & op_ready are both high. op_ready is high only in IDLE, so
//   op_valid is don't-care while a DIV is in flight. Every accepted DIV,
//   MTHI, MTLO or CLRERR produces exactly one single-cycle done pulse
//   (done_err qualifies it); reserved ops are accepted silently.
//
//   Ports
//     clk, rst            rising-edge clock, asynchronous active-high reset
//     op_valid/op/wdata   operation request (op: 001 DIV, 010 MTHI,
//                         011 MTLO, 100 CLRERR, others reserved)
//     op_ready            high while IDLE
//     done/done_err       completion pulse and its fault qualifier
//     err_sticky          set by a faulted DIV, cleared by CLRERR/reset
//     hi/lo               architectural HI/LO registers
//     div_dnd/div_der     registered dividend/divisor to the divider
//     div_quo/div_rem     divider results, valid one edge after sampling
//     div_err             divider fault, same timing as the results
module hilo_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] wdata,
    output logic        op_ready,
    output logic        done,
    output logic        done_err,
    output logic        err_sticky,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [63:0] div_dnd,
    output logic [31:0] div_der,
    input  logic [31:0] div_quo,
    input  logic [31:0] div_rem,
    input  logic        div_err
);

    localparam logic [2:0] OP_DIV    = 3'b001;
    localparam logic [2:0] OP_MTHI   = 3'b010;
    localparam logic [2:0] OP_MTLO   = 3'b011;
    localparam logic [2:0] OP_CLRERR = 3'b100;

    // DRIVE: divider samples div_dnd/div_der at the edge leaving this state.
    // WAIT:  divider results are valid at the edge leaving this state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] dnd_q, dnd_d;
    logic [31:0] der_q, der_d;
    logic        done_q, done_d;
    logic        done_err_q, done_err_d;
    logic        err_q, err_d;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dnd_d      = dnd_q;
        der_d      = der_q;
        err_d      = err_q;
        done_d     = 1'b0;
        done_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // op_ready is 1 here, so op_valid alone means accepted.
                if (op_valid) begin
                    case (op)
                        OP_DIV: begin
                            dnd_d   = {hi_q, lo_q};
                            der_d   = wdata;
                            state_d = ST_DRIVE;
                        end
                        OP_MTHI: begin
                            hi_d   = wdata;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = wdata;
                            done_d = 1'b1;
                        end
                        OP_CLRERR: begin
                            err_d  = 1'b0;
                            done_d = 1'b1;
                        end
                        default: begin
                            // Reserved: accepted, no effect, no done.
                        end
                    endcase
                end
            end
            ST_DRIVE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Only place the divider outputs are looked at, so stale
                // results or faults in other states can never leak in.
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (div_err) begin
                    done_err_d = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    lo_d = div_quo;
                    hi_d = div_rem;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            dnd_q      <= 64'd0;
            der_q      <= 32'd0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dnd_q      <= dnd_d;
            der_q      <= der_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
            err_q      <= err_d;
        end
    end

    assign op_ready   = (state_q == ST_IDLE);
    assign done       = done_q;
    assign done_err   = done_err_q;
    assign err_sticky = err_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign div_dnd    = dnd_q;
    assign div_der    = der_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
module tb_hilo_div_ctrl;

    localparam logic [2:0] OP_DIV    = 3'b001;
    localparam logic [2:0] OP_MTHI   = 3'b010;
    localparam logic [2:0] OP_MTLO   = 3'b011;
    localparam logic [2:0] OP_CLRERR = 3'b100;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] wdata = 32'd0;
    logic        op_ready, done, done_err, err_sticky;
    logic [31:0] hi, lo, div_der;
    logic [63:0] div_dnd;
    logic [31:0] div_quo = 32'd0;
    logic [31:0] div_rem = 32'd0;
    logic        div_err = 1'b0;
    logic        stub_hold = 1'b0;

    always #5 clk = ~clk;

    hilo_div_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .wdata(wdata),
        .op_ready(op_ready), .done(done), .done_err(done_err),
        .err_sticky(err_sticky), .hi(hi), .lo(lo), .div_dnd(div_dnd),
        .div_der(div_der), .div_quo(div_quo), .div_rem(div_rem),
        .div_err(div_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Signed 64/32 division: {err, quotient, remainder}.
    function automatic logic [64:0] ref_div(input logic [63:0] dnd, input logic [31:0] der);
        longint sd, sv, sq, sr;
        longint max_q, min_q, min_d;
        max_q = 64'sh0000_0000_7FFF_FFFF;
        min_q = -64'sh0000_0000_8000_0000;
        min_d = 64'sh8000_0000_0000_0000;
        sd = dnd;
        sv = longint'($signed(der));
        if (sv == 0) return {1'b1, 64'd0};
        if (sd == min_d && sv == -1) return {1'b1, 64'd0};
        sq = sd / sv;
        sr = sd % sv;
        if (sq > max_q || sq < min_q) return {1'b1, 64'd0};
        return {1'b0, sq[31:0], sr[31:0]};
    endfunction

    // ---------------- divider stub (one-edge latency) ----------------
    always @(posedge clk) begin
        logic [64:0] r;
        if (!stub_hold) begin
            r = ref_div(div_dnd, div_der);
            div_err <= r[64];
            div_quo <= r[63:32];
            div_rem <= r[31:0];
        end
    end

    // ---------------- reference model + scoreboard producer ----------------
    // Entry: {due_cycle[31:0], done_err, err_sticky, hi[31:0], lo[31:0]}
    logic [97:0] exp_q[$];
    int          cyc = 0;
    int          busy_until = 0;
    logic        acc_flag = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_der = 32'd0;
    logic [63:0] m_dnd = 64'd0;
    logic        m_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic [64:0] r;
        logic [31:0] due;
        if (rst) begin
            m_hi = 0; m_lo = 0; m_dnd = 0; m_der = 0; m_err = 0;
            busy_until = 0;
            acc_flag = 0;
            exp_q.delete();
        end else begin
            cyc = cyc + 1;
            acc_flag = 0;
            if (op_valid && cyc > busy_until) begin
                acc_flag = 1;
                due = cyc;
                case (op)
                    OP_DIV: begin
                        m_dnd = {m_hi, m_lo};
                        m_der = wdata;
                        r = ref_div(m_dnd, m_der);
                        busy_until = cyc + 2;
                        due = cyc + 2;
                        if (r[64]) m_err = 1'b1;
                        else begin
                            m_lo = r[63:32];
                            m_hi = r[31:0];
                        end
                        exp_q.push_back({due, r[64], m_err, m_hi, m_lo});
                    end
                    OP_MTHI: begin
                        m_hi = wdata;
                        exp_q.push_back({due, 1'b0, m_err, m_hi, m_lo});
                    end
                    OP_MTLO: begin
                        m_lo = wdata;
                        exp_q.push_back({due, 1'b0, m_err, m_hi, m_lo});
                    end
                    OP_CLRERR: begin
                        m_err = 1'b0;
                        exp_q.push_back({due, 1'b0, m_err, m_hi, m_lo});
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ---------------- monitor / scoreboard consumer ----------------
    always @(negedge clk) begin
        logic [97:0] e;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_latency", 64'(cyc), 64'(e[97:66]));
                check("done_err", 64'(done_err), 64'(e[65]));
                check("err_sticky_at_done", 64'(err_sticky), 64'(e[64]));
                check("hi_at_done", 64'(hi), 64'(e[63:32]));
                check("lo_at_done", 64'(lo), 64'(e[31:0]));
            end
        end else begin
            check("done_err_without_done", 64'(done_err), 64'd0);
            if (exp_q.size() > 0 && int'(exp_q[0][97:66]) < cyc) begin
                e = exp_q.pop_front();
                check("missing_done", 64'(done), 64'd1);
            end
        end
        if (exp_q.size() == 0) begin
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
            check("err_sticky", 64'(err_sticky), 64'(m_err));
        end
        check("op_ready", 64'(op_ready), 64'(cyc >= busy_until));
        check("div_dnd", div_dnd, m_dnd);
        check("div_der", 64'(div_der), 64'(m_der));
    end

    // ---------------- driver ----------------
    task automatic do_op(input logic [2:0] o, input logic [31:0] d);
        int budget;
        budget = 20;
        op_valid = 1'b1;
        op = o;
        wdata = d;
        do begin
            @(posedge clk);
            #1;
            budget--;
        end while (!acc_flag && budget > 0);
        check("accept_timeout", 64'(acc_flag), 64'd1);
        op_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int          sel;
        logic [31:0] d;
        logic [2:0]  ro;
        logic [2:0]  rsv [4];
        rsv[0] = 3'b000; rsv[1] = 3'b101; rsv[2] = 3'b110; rsv[3] = 3'b111;

        // Reset held over a few edges; monitor checks reset values meanwhile.
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Basic positive division: 100 / 7.
        do_op(OP_MTHI, 32'd0);
        do_op(OP_MTLO, 32'd100);
        do_op(OP_DIV, 32'd7);
        idle(3);

        // Negative dividend: -100 / 7.
        do_op(OP_MTHI, 32'hFFFF_FFFF);
        do_op(OP_MTLO, 32'hFFFF_FF9C);
        do_op(OP_DIV, 32'd7);
        idle(3);

        // Divide by zero faults, then CLRERR.
        do_op(OP_MTHI, 32'd0);
        do_op(OP_MTLO, 32'd5);
        do_op(OP_DIV, 32'd0);
        idle(3);
        do_op(OP_CLRERR, 32'd0);
        idle(2);

        // MTLO held during the DIV: accepted on the edge after done.
        do_op(OP_DIV, 32'd3);
        do_op(OP_MTLO, 32'h55);
        idle(2);

        // Reserved op 111.
        do_op(3'b111, 32'hDEAD_BEEF);
        idle(3);

        // Reset pulsed during WAIT while the divider holds a valid result.
        do_op(OP_MTHI, 32'd0);
        do_op(OP_MTLO, 32'd50);
        op_valid = 1'b1; op = OP_DIV; wdata = 32'd5;
        @(posedge clk); #1;          // accept edge -> DRIVE
        op_valid = 1'b0;
        @(posedge clk); #1;          // divider samples -> WAIT
        stub_hold = 1'b1;            // keep quo=10/rem=0 presented
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        idle(4);
        stub_hold = 1'b0;
        check("hi_after_abort", 64'(hi), 64'd0);
        check("lo_after_abort", 64'(lo), 64'd0);
        do_op(OP_MTLO, 32'd9);       // first edge after release accepts
        idle(2);

        // Randomized mix.
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1: begin
                    d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 3));
                    do_op(OP_MTHI, d);
                end
                2, 3: do_op(OP_MTLO, $urandom);
                4, 5: begin
                    d = 32'($urandom_range(0, 40)) - 32'd20;
                    do_op(OP_DIV, d);
                end
                6: do_op(OP_DIV, $urandom);
                7: do_op(OP_CLRERR, $urandom);
                8: begin
                    ro = rsv[$urandom_range(0, 3)];
                    do_op(ro, $urandom);
                end
                default: do_op(OP_MTHI, $urandom);
            endcase
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(5);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
